bt656_timing_extract: RTL and testbench

Parses the 8-bit ITU-R BT.656 stream from the ADV7180 pixel port (27 MHz line-locked clock) into field and blanking flags, a luma/chroma-tagged active-pixel strobe and line/pixel counters. Sits directly upstream of the decode/SRAM-write stage and the histogram equalizer, which consume these strobes instead of re-parsing timing reference codes themselves. Also flags malformed or missing timing codes for the watchdog and status logic.

---
 rtl/bt656_timing_extract.sv | 203 ++++++++++++++++++++
 tb/tb_bt656_timing_extract.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt656_timing_extract.sv
// BT.656 timing-reference parser: recovers F/V/H flags, tags active Cb/Y/Cr/Y samples,
// keeps luma/line counters and reports malformed or overrunning timing codes.
module bt656_timing_extract #(
    parameter int LINE_PIXELS = 720,
    parameter int MAX_LINES   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic [7:0] din,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       pix_is_luma,
    output logic [9:0] pix_cnt,
    output logic [9:0] line_cnt,
    output logic       field,
    output logic       vblank,
    output logic       hblank,
    output logic       field_start,
    output logic       line_start,
    output logic       sync_err
);

    localparam logic [10:0] LINE_BYTES = 11'(2 * LINE_PIXELS);
    localparam logic [9:0]  LINE_MAX   = 10'(MAX_LINES);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_FF   = 3'd1,
        ST_Z1   = 3'd2,
        ST_Z2   = 3'd3,
        ST_XY   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        active_q, active_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        pix_is_luma_q, pix_is_luma_d;
    logic [9:0]  pix_cnt_q, pix_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        field_q, field_d;
    logic        vblank_q, vblank_d;
    logic        hblank_q, hblank_d;
    logic        field_start_q, field_start_d;
    logic        line_start_q, line_start_d;
    logic        sync_err_q, sync_err_d;

    // XY byte: bit7 set and the four Hamming protection bits consistent with F/V/H.
    function automatic logic xy_ok(input logic [7:0] xy);
        logic f;
        logic v;
        logic h;
        f = xy[6];
        v = xy[5];
        h = xy[4];
        return xy[7] && (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    endfunction

    // Next-state and output computation for the byte-level parser.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        byte_cnt_d    = byte_cnt_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = 1'b0;
        pix_is_luma_d = pix_is_luma_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        field_d       = field_q;
        vblank_d      = vblank_q;
        hblank_d      = hblank_q;
        field_start_d = 1'b0;
        line_start_d  = 1'b0;
        sync_err_d    = 1'b0;

        if (!capture) begin
            state_d  = ST_HUNT;
            active_d = 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (din == 8'hFF) begin
                        // A preamble always terminates any active run, even a legal EAV.
                        state_d  = ST_FF;
                        active_d = 1'b0;
                    end else if (active_q) begin
                        if (byte_cnt_q >= LINE_BYTES) begin
                            sync_err_d = 1'b1;
                            active_d   = 1'b0;
                        end else begin
                            pix_valid_d   = 1'b1;
                            pix_data_d    = din;
                            pix_is_luma_d = byte_cnt_q[0];
                            pix_cnt_d     = byte_cnt_q[10:1];
                            byte_cnt_d    = byte_cnt_q + 11'd1;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_FF: begin
                    if (din == 8'h00) begin
                        state_d = ST_Z1;
                    end else begin
                        state_d    = ST_HUNT;
                        sync_err_d = 1'b1;
                    end
                end
                ST_Z1: begin
                    if (din == 8'h00) begin
                        state_d = ST_Z2;
                    end else begin
                        state_d    = ST_HUNT;
                        sync_err_d = 1'b1;
                    end
                end
                ST_Z2: begin
                    state_d = ST_HUNT;
                    if (!xy_ok(din)) begin
                        sync_err_d = 1'b1;
                    end else begin
                        field_d  = din[6];
                        vblank_d = din[5];
                        hblank_d = din[4];
                        if (!din[4] && !din[5]) begin
                            active_d     = 1'b1;
                            byte_cnt_d   = 11'd0;
                            line_start_d = 1'b1;
                            // Previous code in vertical blanking means this is line 0 of a field.
                            if (vblank_q) begin
                                field_start_d = 1'b1;
                                line_cnt_d    = 10'd0;
                            end else if (line_cnt_q != LINE_MAX) begin
                                line_cnt_d = line_cnt_q + 10'd1;
                            end else begin
                                line_cnt_d = line_cnt_q;
                            end
                        end else begin
                            active_d = 1'b0;
                        end
                    end
                end
                ST_XY: begin
                    state_d = ST_HUNT;
                end
                default: begin
                    state_d  = ST_HUNT;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            active_q      <= 1'b0;
            byte_cnt_q    <= 11'd0;
            pix_data_q    <= 8'd0;
            pix_valid_q   <= 1'b0;
            pix_is_luma_q <= 1'b0;
            pix_cnt_q     <= 10'd0;
            line_cnt_q    <= 10'd0;
            field_q       <= 1'b0;
            vblank_q      <= 1'b1;
            hblank_q      <= 1'b1;
            field_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            byte_cnt_q    <= byte_cnt_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_is_luma_q <= pix_is_luma_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            field_q       <= field_d;
            vblank_q      <= vblank_d;
            hblank_q      <= hblank_d;
            field_start_q <= field_start_d;
            line_start_q  <= line_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_is_luma = pix_is_luma_q;
    assign pix_cnt     = pix_cnt_q;
    assign line_cnt    = line_cnt_q;
    assign field       = field_q;
    assign vblank      = vblank_q;
    assign hblank      = hblank_q;
    assign field_start = field_start_q;
    assign line_start  = line_start_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_bt656_timing_extract.sv
// Scoreboard bench for bt656_timing_extract: stimulus pushes expected output events,
// a monitor pops and compares them whenever the DUT raises a strobe.
module tb_bt656_timing_extract;

    logic       clk = 1'b0;
    logic       rst;
    logic       capture;
    logic [7:0] din;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_is_luma;
    logic [9:0] pix_cnt;
    logic [9:0] line_cnt;
    logic       field;
    logic       vblank;
    logic       hblank;
    logic       field_start;
    logic       line_start;
    logic       sync_err;

    bt656_timing_extract dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .din         (din),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_is_luma (pix_is_luma),
        .pix_cnt     (pix_cnt),
        .line_cnt    (line_cnt),
        .field       (field),
        .vblank      (vblank),
        .hblank      (hblank),
        .field_start (field_start),
        .line_start  (line_start),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       pv;
        logic       luma;
        logic [7:0] data;
        logic [9:0] pcnt;
        logic       ls;
        logic       fs;
        logic [9:0] lcnt;
        logic       se;
        logic       f;
        logic       v;
        logic       h;
    } ev_t;

    ev_t  expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic ef = 1'b0;
    logic ev = 1'b1;
    logic eh = 1'b1;

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        din = b;
    endtask

    // Expected event for the byte just issued: it appears one cycle later.
    task automatic exp_ev(input logic pv, input logic luma, input logic [7:0] data,
                          input logic [9:0] pcnt, input logic ls, input logic fs,
                          input logic [9:0] lcnt, input logic se);
        ev_t e;
        e.cyc = cyc + 1;
        e.pv = pv; e.luma = luma; e.data = data; e.pcnt = pcnt;
        e.ls = ls; e.fs = fs; e.lcnt = lcnt; e.se = se;
        e.f = ef; e.v = ev; e.h = eh;
        expq.push_back(e);
    endtask

    task automatic send_code(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
    endtask

    task automatic sav(input logic fs, input logic [9:0] lcnt);
        send_code(8'h80);
        ef = 1'b0; ev = 1'b0; eh = 1'b0;
        exp_ev(1'b0, 1'b0, 8'h00, 10'd0, 1'b1, fs, lcnt, 1'b0);
    endtask

    task automatic eav(input logic [7:0] xy);
        send_code(xy);
        ef = xy[6]; ev = xy[5]; eh = xy[4];
    endtask

    task automatic pixels(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'h10 + 8'(i % 224);
            send(b);
            exp_ev(1'b1, 1'(i % 2), b, 10'(i / 2), 1'b0, 1'b0, 10'd0, 1'b0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_is_luma"}, 32'(pix_is_luma), 32'd0);
        chk({tag, "_pix_cnt"}, 32'(pix_cnt), 32'd0);
        chk({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
        chk({tag, "_fvh"}, {29'd0, field, vblank, hblank}, 32'h3);
        chk({tag, "_pulses"}, {29'd0, field_start, line_start, sync_err}, 32'h0);
    endtask

    task automatic chk_flags(input string tag);
        @(negedge clk);
        chk({tag, "_fvh"}, {29'd0, field, vblank, hblank}, {29'd0, ef, ev, eh});
    endtask

    // Monitor: every strobe cycle must match the oldest expected event.
    initial begin
        ev_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if ((pix_valid | line_start | field_start | sync_err) === 1'b1) begin
                n_chk++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d actual pv=%b ls=%b fs=%b se=%b required none",
                             cyc, pix_valid, line_start, field_start, sync_err);
                end else begin
                    e = expq.pop_front();
                    ok = (cyc == e.cyc) && (pix_valid === e.pv) && (line_start === e.ls) &&
                         (field_start === e.fs) && (sync_err === e.se) && (field === e.f) &&
                         (vblank === e.v) && (hblank === e.h) &&
                         (!e.pv || ((pix_data === e.data) && (pix_is_luma === e.luma) &&
                                    (pix_cnt === e.pcnt))) &&
                         (!e.ls || (line_cnt === e.lcnt));
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL event actual cyc=%0d pv=%b d=%h y=%b pc=%0d ls=%b fs=%b lc=%0d se=%b fvh=%b%b%b required cyc=%0d pv=%b d=%h y=%b pc=%0d ls=%b fs=%b lc=%0d se=%b fvh=%b%b%b",
                                 cyc, pix_valid, pix_data, pix_is_luma, pix_cnt, line_start,
                                 field_start, line_cnt, sync_err, field, vblank, hblank,
                                 e.cyc, e.pv, e.data, e.luma, e.pcnt, e.ls, e.fs, e.lcnt, e.se,
                                 e.f, e.v, e.h);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        capture = 1'b1;
        din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("reset");

        // Vertical-blanking EAV, then three active lines of one field.
        eav(8'hB6);
        send(8'h00);
        chk_flags("eav_b6");
        sav(1'b1, 10'd0);
        pixels(1440);
        eav(8'h9D);
        send(8'h00);
        chk_flags("eav_9d");
        @(negedge clk);
        chk("line1_pix_cnt", 32'(pix_cnt), 32'd719);
        sav(1'b0, 10'd1);
        pixels(1440);
        eav(8'h9D);
        sav(1'b0, 10'd2);
        pixels(1440);
        eav(8'h9D);
        send(8'h00);
        @(negedge clk);
        chk("line3_line_cnt", 32'(line_cnt), 32'd2);

        // Corrupt XY byte: error pulse, flags untouched, no pixels afterwards.
        send_code(8'h81);
        exp_ev(1'b0, 1'b0, 8'h00, 10'd0, 1'b0, 1'b0, 10'd0, 1'b1);
        repeat (4) send(8'h55);
        chk_flags("bad_xy");

        // Overrun: 1442 bytes before EAV, byte 1441 flags an error.
        sav(1'b0, 10'd3);
        pixels(1440);
        send(8'h60);
        exp_ev(1'b0, 1'b0, 8'h00, 10'd0, 1'b0, 1'b0, 10'd0, 1'b1);
        send(8'h61);
        eav(8'h9D);

        // capture dropped mid-line for 10 cycles.
        sav(1'b0, 10'd4);
        pixels(100);
        @(posedge clk);
        #1;
        capture = 1'b0;
        din = 8'h30;
        repeat (9) send(8'h31);
        @(negedge clk);
        chk("cap_low_pix_cnt", 32'(pix_cnt), 32'd49);
        chk("cap_low_line_cnt", 32'(line_cnt), 32'd4);
        @(posedge clk);
        #1;
        capture = 1'b1;
        din = 8'h40;
        repeat (19) send(8'h41);
        @(negedge clk);
        chk("cap_high_pix_cnt", 32'(pix_cnt), 32'd49);
        chk("cap_high_line_cnt", 32'(line_cnt), 32'd4);
        chk("cap_high_pix_valid", 32'(pix_valid), 32'd0);
        eav(8'h9D);
        sav(1'b0, 10'd5);
        pixels(4);
        eav(8'h9D);

        // Reset mid-line, then the rest of the line, EAV and a fresh SAV.
        sav(1'b0, 10'd6);
        pixels(50);
        @(posedge clk);
        #1;
        rst = 1'b1;
        din = 8'h55;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ef = 1'b0; ev = 1'b1; eh = 1'b1;
        chk_reset_vals("mid_rst");
        repeat (30) send(8'h56);
        eav(8'h9D);
        sav(1'b0, 10'd1);
        pixels(4);
        eav(8'h9D);

        repeat (5) send(8'h00);
        @(negedge clk);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
